// File: rtl/gate_sweep_checker.sv
// Sweeps A/B through 00,01,10,11, lets the three gate-set builds settle, then
// compares their outputs to locally computed values. Optional macro: GATE_SWEEP_STOP_ON_FAIL_EN.
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] y_basic,
    input  logic [6:0] y_nand,
    input  logic [6:0] y_nor,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_mask,
    output logic [3:0] err_count,
    output logic [1:0] first_fail
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_combo;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_fail_mask;
    logic [3:0] r_err_count;
    logic [1:0] r_first_fail;

    state_t     w_state_next;
    logic [1:0] w_combo_next;
    logic [3:0] w_cnt_next;
    logic       w_a_next;
    logic       w_b_next;
    logic       w_busy_next;
    logic       w_done_next;
    logic       w_pass_next;
    logic [2:0] w_fail_mask_next;
    logic [3:0] w_err_count_next;
    logic [1:0] w_first_fail_next;

    logic       w_ea;
    logic       w_eb;
    logic [6:0] w_expected;
    logic [6:0] w_y [3];
    logic [2:0] w_mismatch;
    logic [3:0] w_sample_errs;
    logic       w_any_mismatch;

    // Expected vector follows the combination index, not the A/B pins themselves
    assign w_ea       = r_combo[1];
    assign w_eb       = r_combo[0];
    assign w_expected = {~(w_ea ^ w_eb), w_ea ^ w_eb, ~(w_ea | w_eb), ~(w_ea & w_eb),
                         w_ea | w_eb, w_ea & w_eb, ~w_ea};

    assign w_y[0] = y_basic;
    assign w_y[1] = y_nand;
    assign w_y[2] = y_nor;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cmp
            assign w_mismatch[gi] = (w_y[gi] != w_expected);
        end
    endgenerate

    assign w_sample_errs  = {3'b000, w_mismatch[0]} + {3'b000, w_mismatch[1]}
                          + {3'b000, w_mismatch[2]};
    assign w_any_mismatch = |w_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_combo      <= 2'b00;
            r_cnt        <= 4'd0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_mask  <= 3'b000;
            r_err_count  <= 4'd0;
            r_first_fail <= 2'b00;
        end else begin
            r_state      <= w_state_next;
            r_combo      <= w_combo_next;
            r_cnt        <= w_cnt_next;
            r_a          <= w_a_next;
            r_b          <= w_b_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_pass       <= w_pass_next;
            r_fail_mask  <= w_fail_mask_next;
            r_err_count  <= w_err_count_next;
            r_first_fail <= w_first_fail_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_combo_next      = r_combo;
        w_cnt_next        = r_cnt;
        w_a_next          = r_a;
        w_b_next          = r_b;
        w_busy_next       = r_busy;
        w_done_next       = 1'b0;
        w_pass_next       = r_pass;
        w_fail_mask_next  = r_fail_mask;
        w_err_count_next  = r_err_count;
        w_first_fail_next = r_first_fail;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_combo_next      = 2'b00;
                    w_a_next          = 1'b0;
                    w_b_next          = 1'b0;
                    w_cnt_next        = 4'd0;
                    w_busy_next       = 1'b1;
                    w_pass_next       = 1'b0;
                    w_fail_mask_next  = 3'b000;
                    w_err_count_next  = 4'd0;
                    w_first_fail_next = 2'b00;
                    w_state_next      = S_SETTLE;
                end
            end

            S_SETTLE: begin
                w_cnt_next = r_cnt + 4'd1;
                if (r_cnt == LP_CNT_LAST) begin
                    w_state_next = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                w_fail_mask_next = r_fail_mask | w_mismatch;
                w_err_count_next = r_err_count + w_sample_errs;
                // A zero running count means no earlier sample of this sweep mismatched
                if (w_any_mismatch && (r_err_count == 4'd0)) begin
                    w_first_fail_next = r_combo;
                end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                if (w_any_mismatch) begin
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_pass_next  = 1'b0;
                    w_state_next = S_IDLE;
                end else
`endif
                if (r_combo != 2'b11) begin
                    w_combo_next = r_combo + 2'b01;
                    w_a_next     = w_combo_next[1];
                    w_b_next     = w_combo_next[0];
                    w_cnt_next   = 4'd0;
                    w_state_next = S_SETTLE;
                end else begin
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_pass_next  = (r_err_count == 4'd0) && !w_any_mismatch;
                    w_combo_next = 2'b00;
                    w_a_next     = 1'b0;
                    w_b_next     = 1'b0;
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign A          = r_a;
    assign B          = r_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_mask  = r_fail_mask;
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a behavioural gate set with injectable
// faults feeds the checker, and each task compares against hand-computed results.
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] y_basic;
    logic [6:0] y_nand;
    logic [6:0] y_nor;
    logic       A;
    logic       B;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_mask;
    logic [3:0] err_count;
    logic [1:0] first_fail;

    logic       f_nand_xor0 = 1'b0;
    logic       f_not1      = 1'b0;

    int         checks = 0;
    int         errors = 0;
    int         done_at;
    logic [1:0] ab_log [0:15];

    always #5 clk = ~clk;

    gate_sweep_checker #(.SETTLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .y_basic   (y_basic),
        .y_nand    (y_nand),
        .y_nor     (y_nor),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .err_count (err_count),
        .first_fail(first_fail)
    );

    // Three correct gate builds, with stuck-at faults layered on top
    always_comb begin
        y_basic = {~(A ^ B), A ^ B, ~(A | B), ~(A & B), A | B, A & B, ~A};
        y_nand  = y_basic;
        y_nor   = y_basic;
        if (f_nand_xor0) y_nand[5] = 1'b0;
        if (f_not1) begin
            y_basic[0] = 1'b1;
            y_nor[0]   = 1'b1;
        end
    end

    // Counts edges after the start edge until done, logging {A,B} after each edge
    task automatic wait_done(input int p1, input int p2);
        done_at   = -1;
        ab_log[0] = {A, B};
        for (int n = 1; n <= 30; n++) begin
            start = (n == p1) || (n == p2);
            @(posedge clk); #1;
            if (n < 16) ab_log[n] = {A, B};
            if (done) begin
                done_at = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic do_sweep(input int p1, input int p2);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(p1, p2);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({A, B} !== 2'b00) begin errors++; $display("FAIL reset_ab got %b want 00", {A, B}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
        checks++; if (fail_mask !== 3'b000) begin errors++; $display("FAIL reset_mask got %b want 000", fail_mask); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL reset_errs got %0d want 0", err_count); end
        checks++; if (first_fail !== 2'b00) begin errors++; $display("FAIL reset_first got %b want 00", first_fail); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_sweep;
        do_sweep(0, 0);
        checks++; if (done_at !== 12) begin errors++; $display("FAIL clean_done_at got %0d want 12", done_at); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass got %b want 1", pass); end
        checks++; if (fail_mask !== 3'b000) begin errors++; $display("FAIL clean_mask got %b want 000", fail_mask); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL clean_errs got %0d want 0", err_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy got %b want 0", busy); end
        checks++; if ({A, B} !== 2'b00) begin errors++; $display("FAIL clean_ab_end got %b want 00", {A, B}); end
        for (int i = 0; i < 12; i++) begin
            logic [1:0] want_ab;
            want_ab = 2'(i / 3);
            checks++;
            if (ab_log[i] !== want_ab) begin
                errors++;
                $display("FAIL clean_ab_seq[%0d] got %b want %b", i, ab_log[i], want_ab);
            end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clean_done_pulse got %b want 0", done); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass_hold got %b want 1", pass); end
    endtask

    task automatic test_nand_xor_fault;
        f_nand_xor0 = 1'b1;
        do_sweep(0, 0);
        f_nand_xor0 = 1'b0;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        checks++; if (done_at !== 6) begin errors++; $display("FAIL xor_done_at got %0d want 6", done_at); end
        checks++; if ({A, B} !== 2'b01) begin errors++; $display("FAIL xor_ab_hold got %b want 01", {A, B}); end
        checks++; if (err_count !== 4'd1) begin errors++; $display("FAIL xor_errs got %0d want 1", err_count); end
`else
        checks++; if (done_at !== 12) begin errors++; $display("FAIL xor_done_at got %0d want 12", done_at); end
        checks++; if ({A, B} !== 2'b00) begin errors++; $display("FAIL xor_ab_end got %b want 00", {A, B}); end
        checks++; if (err_count !== 4'd2) begin errors++; $display("FAIL xor_errs got %0d want 2", err_count); end
`endif
        checks++; if (fail_mask !== 3'b010) begin errors++; $display("FAIL xor_mask got %b want 010", fail_mask); end
        checks++; if (first_fail !== 2'b01) begin errors++; $display("FAIL xor_first got %b want 01", first_fail); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL xor_pass got %b want 0", pass); end
    endtask

    task automatic test_not_stuck;
        f_not1 = 1'b1;
        do_sweep(0, 0);
        f_not1 = 1'b0;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        checks++; if (done_at !== 9) begin errors++; $display("FAIL not_done_at got %0d want 9", done_at); end
        checks++; if (err_count !== 4'd2) begin errors++; $display("FAIL not_errs got %0d want 2", err_count); end
`else
        checks++; if (done_at !== 12) begin errors++; $display("FAIL not_done_at got %0d want 12", done_at); end
        checks++; if (err_count !== 4'd4) begin errors++; $display("FAIL not_errs got %0d want 4", err_count); end
`endif
        checks++; if (fail_mask !== 3'b101) begin errors++; $display("FAIL not_mask got %b want 101", fail_mask); end
        checks++; if (first_fail !== 2'b10) begin errors++; $display("FAIL not_first got %b want 10", first_fail); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL not_pass got %b want 0", pass); end
    endtask

    task automatic test_start_ignored;
        do_sweep(3, 7);
        checks++; if (done_at !== 12) begin errors++; $display("FAIL ign_done_at got %0d want 12", done_at); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ign_pass got %b want 1", pass); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL ign_errs got %0d want 0", err_count); end
        checks++; if (ab_log[4] !== 2'b01) begin errors++; $display("FAIL ign_ab4 got %b want 01", ab_log[4]); end
        checks++; if (ab_log[8] !== 2'b10) begin errors++; $display("FAIL ign_ab8 got %b want 10", ab_log[8]); end
    endtask

    task automatic test_back_to_back;
        f_nand_xor0 = 1'b1;
        do_sweep(0, 0);
        f_nand_xor0 = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_seen got %b want 1", done); end
        // start asserted in the done cycle restarts immediately and clears results
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL b2b_errs_clr got %0d want 0", err_count); end
        checks++; if (fail_mask !== 3'b000) begin errors++; $display("FAIL b2b_mask_clr got %b want 000", fail_mask); end
        checks++; if (first_fail !== 2'b00) begin errors++; $display("FAIL b2b_first_clr got %b want 00", first_fail); end
        wait_done(0, 0);
        checks++; if (done_at !== 12) begin errors++; $display("FAIL b2b_done_at got %0d want 12", done_at); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL b2b_pass got %b want 1", pass); end
    endtask

    task automatic test_mid_reset;
        int saw_done;
        saw_done = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({A, B} !== 2'b00) begin errors++; $display("FAIL mrst_ab got %b want 00", {A, B}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", busy); end
        checks++; if ({done, pass, fail_mask, err_count, first_fail} !== 11'd0) begin
            errors++;
            $display("FAIL mrst_outputs got %b want 0", {done, pass, fail_mask, err_count, first_fail});
        end
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        checks++; if (saw_done !== 0) begin errors++; $display("FAIL mrst_no_done got %0d want 0", saw_done); end
        do_sweep(0, 0);
        checks++; if (done_at !== 12) begin errors++; $display("FAIL mrst_done_at got %0d want 12", done_at); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL mrst_pass got %b want 1", pass); end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_nand_xor_fault();
        test_not_stuck();
        test_start_ignored();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
